// File: rtl/skf_pkg.sv
// skf_pkg: shared state type, default width and reference predicate for the Skolem checker
package skf_pkg;
  localparam int SKF_W_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, SWEEP, CHECK, DONE} skf_state_e;
  // P(x,s,t): unsigned quotient (all-ones on zero divisor) compared signed against t
  function automatic logic skf_pred(input logic [SKF_W_DEFAULT-1:0] x, s, t);
    logic [SKF_W_DEFAULT-1:0] q;
    q = (s == '0) ? '1 : x / s;
    return $signed(q) >= $signed(t);
  endfunction
endpackage

// File: rtl/skf_inv_check_seq_if.sv
// skf_inv_check_seq_if: run handshake, Skolem operand bus and result counters (first-fail log under SKF_FAIL_LOG_EN)
interface skf_inv_check_seq_if
  import skf_pkg::*;
#(
  parameter int W  = SKF_W_DEFAULT,
  parameter int CW = 2*W+1
);
  logic          start;
  logic          busy;
  logic          done;
  logic [W-1:0]  skf_s;
  logic [W-1:0]  skf_t;
  logic [W-1:0]  skf_x;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] unsat_cnt;
`ifdef SKF_FAIL_LOG_EN
  logic          first_fail_vld;
  logic [W-1:0]  first_fail_s;
  logic [W-1:0]  first_fail_t;
  logic [W-1:0]  first_fail_x;
`endif
  modport master (
    input  start, skf_x,
    output busy, done, skf_s, skf_t, pass_cnt, fail_cnt, unsat_cnt
`ifdef SKF_FAIL_LOG_EN
    , output first_fail_vld, first_fail_s, first_fail_t, first_fail_x
`endif
  );
  modport slave (
    output start, skf_x,
    input  busy, done, skf_s, skf_t, pass_cnt, fail_cnt, unsat_cnt
`ifdef SKF_FAIL_LOG_EN
    , input first_fail_vld, first_fail_s, first_fail_t, first_fail_x
`endif
  );
endinterface

// File: rtl/skf_udiv_w.sv
// skf_udiv_w: combinational W-bit unsigned divider returning all-ones on a zero divisor
module skf_udiv_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic [W-1:0] quo
);
  assign quo = (den == '0) ? '1 : num / den;
endmodule

// File: rtl/skf_inv_check_seq.sv
// skf_inv_check_seq: sweeps every (s,t), finds ground truth over all x, grades the Skolem x; SKF_FAIL_LOG_EN adds a first-failure log
module skf_inv_check_seq
  import skf_pkg::*;
#(
  parameter int W  = SKF_W_DEFAULT,
  parameter int CW = 2*W+1
) (
  input logic                 clk,
  input logic                 rst_n,
  skf_inv_check_seq_if.master bus
);
  skf_state_e   state;
  logic [W-1:0] x_cnt;
  logic         exists;
  logic [W-1:0] q_sweep;
  logic [W-1:0] q_skf;
  logic         p_sweep;
  logic         p_skf;

  skf_udiv_w #(.W(W)) u_div_sweep (.num(x_cnt),     .den(bus.skf_s), .quo(q_sweep));
  skf_udiv_w #(.W(W)) u_div_skf   (.num(bus.skf_x), .den(bus.skf_s), .quo(q_skf));

  assign p_sweep = $signed(q_sweep) >= $signed(bus.skf_t);
  assign p_skf   = $signed(q_skf)   >= $signed(bus.skf_t);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // sequencer FSM: sweep x per pair, grade skf_x at CHECK, advance {t,s}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_cnt         <= '0;
      exists        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.skf_s     <= '0;
      bus.skf_t     <= '0;
      bus.pass_cnt  <= '0;
      bus.fail_cnt  <= '0;
      bus.unsat_cnt <= '0;
`ifdef SKF_FAIL_LOG_EN
      bus.first_fail_vld <= 1'b0;
      bus.first_fail_s   <= '0;
      bus.first_fail_t   <= '0;
      bus.first_fail_x   <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state         <= SWEEP;
          bus.busy      <= 1'b1;
          x_cnt         <= '0;
          exists        <= 1'b0;
          bus.skf_s     <= '0;
          bus.skf_t     <= '0;
          bus.pass_cnt  <= '0;
          bus.fail_cnt  <= '0;
          bus.unsat_cnt <= '0;
`ifdef SKF_FAIL_LOG_EN
          bus.first_fail_vld <= 1'b0;
          bus.first_fail_s   <= '0;
          bus.first_fail_t   <= '0;
          bus.first_fail_x   <= '0;
`endif
        end
        SWEEP: begin
          exists <= exists | p_sweep;
          x_cnt  <= x_cnt + 1'b1;
          if (x_cnt == '1) state <= CHECK;
        end
        CHECK: begin
          if (!exists) bus.unsat_cnt <= sat_inc(bus.unsat_cnt);
          else if (p_skf) bus.pass_cnt <= sat_inc(bus.pass_cnt);
          else bus.fail_cnt <= sat_inc(bus.fail_cnt);
`ifdef SKF_FAIL_LOG_EN
          if (exists && !p_skf && !bus.first_fail_vld) begin
            bus.first_fail_vld <= 1'b1;
            bus.first_fail_s   <= bus.skf_s;
            bus.first_fail_t   <= bus.skf_t;
            bus.first_fail_x   <= bus.skf_x;
          end
`endif
          exists <= 1'b0;
          x_cnt  <= '0;
          if ({bus.skf_t, bus.skf_s} == '1) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            {bus.skf_t, bus.skf_s} <= {bus.skf_t, bus.skf_s} + 1'b1;
            state <= SWEEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_skf_inv_check_seq.sv
// tb_skf_inv_check_seq: table-driven full runs against a behavioural Skolem-checker model, plus restart, reset and back-to-back sequences
module tb_skf_inv_check_seq;
  localparam int W   = 4;
  localparam int CW  = 2*W+1;
  localparam int N   = 1 << W;
  localparam int NP  = N * N;
  localparam int RUN = NP * (N + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  logic [W-1:0] rnd_tab [NP];

  skf_inv_check_seq_if #(.W(W), .CW(CW)) bus ();
  skf_inv_check_seq #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int md;
    int p;
    int f;
    int u;
    int fv;
    int fs;
    int ft;
    int fx;
  } vec_t;

  vec_t tab [4];
  int nvec = 0;
  int nerr = 0;
  int pre_p [NP];
  int pre_f [NP];
  int pre_u [NP];
  int m_fv, m_fs, m_ft, m_fx;

  function automatic bit pred(int x, int s, int t);
    int q  = (s == 0) ? N - 1 : x / s;
    int qs = (q >= N/2) ? q - N : q;
    int ts = (t >= N/2) ? t - N : t;
    return qs >= ts;
  endfunction

  // Skolem stand-ins: 0 oracle, 1 stuck-at-zero, 2 random table, 3 constant all-ones
  function automatic logic [W-1:0] skolem(int md, int s, int t, logic [W-1:0] r);
    if (md == 1) return '0;
    if (md == 2) return r;
    if (md == 3) return '1;
    for (int x = 0; x < N; x++) if (pred(x, s, t)) return W'(x);
    return '0;
  endfunction

  assign bus.skf_x = skolem(mode, int'(bus.skf_s), int'(bus.skf_t), rnd_tab[{bus.skf_t, bus.skf_s}]);

  task automatic model(input int md);
    int p = 0, f = 0, u = 0;
    m_fv = 0; m_fs = 0; m_ft = 0; m_fx = 0;
    for (int i = 0; i < NP; i++) begin
      int s = i % N, t = i / N, xs;
      bit ex = 0;
      for (int x = 0; x < N; x++) ex |= pred(x, s, t);
      xs = int'(skolem(md, s, t, rnd_tab[i]));
      if (!ex) u++;
      else if (pred(xs, s, t)) p++;
      else begin
        f++;
        if (m_fv == 0) begin m_fv = 1; m_fs = s; m_ft = t; m_fx = xs; end
      end
      pre_p[i] = p; pre_f[i] = f; pre_u[i] = u;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_prefix(input string tag, input int k);
    chk({tag, "_pass"},  int'(bus.pass_cnt),  (k < 0) ? 0 : pre_p[k]);
    chk({tag, "_fail"},  int'(bus.fail_cnt),  (k < 0) ? 0 : pre_f[k]);
    chk({tag, "_unsat"}, int'(bus.unsat_cnt), (k < 0) ? 0 : pre_u[k]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_pass"},  int'(bus.pass_cnt), 0);
    chk({tag, "_fail"},  int'(bus.fail_cnt), 0);
    chk({tag, "_unsat"}, int'(bus.unsat_cnt), 0);
    chk({tag, "_skf_st"}, int'({bus.skf_t, bus.skf_s}), 0);
`ifdef SKF_FAIL_LOG_EN
    chk({tag, "_ff_vld"}, int'(bus.first_fail_vld), 0);
`endif
  endtask

  // one run: start pulse, per-pair counter tracking, optional mid-run restart or reset
  task automatic run(input int md, input int repulse, input int abort_at, output int cyc);
    model(md);
    mode = md;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    chk_prefix("cleared_on_start", -1);
    cyc = 0;
    while (1) begin
      int k, r;
      @(posedge clk);
      #1 cyc++;
      if (cyc == repulse) bus.start = 1'b1;
      if (cyc == repulse + 1) bus.start = 1'b0;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1 chk_zero("async_reset");
        return;
      end
      k = cyc / (N + 1);
      r = cyc % (N + 1);
      if (r == N && k < NP) begin
        chk_prefix("pre_check", k - 1);
        chk("pair_idx_check", int'({bus.skf_t, bus.skf_s}), k);
      end
      if (r == 0 && k > 0) begin
        chk_prefix("post_check", k - 1);
        if (md == 3 && k - 1 == 31) chk("spot_s15_t1_pass_inc", int'(bus.pass_cnt) - pre_p[30], 1);
        if (md == 3 && k - 1 == 112) chk("spot_s0_t7_unsat_inc", int'(bus.unsat_cnt) - pre_u[111], 1);
        if (k < NP) chk("pair_idx_sweep", int'({bus.skf_t, bus.skf_s}), k);
      end
      if (bus.done || cyc > RUN + 100) break;
    end
    chk("done_cycle", cyc, RUN);
    chk("busy_in_done", int'(bus.busy), 0);
    @(posedge clk);
    #1 chk("done_one_cycle", int'(bus.done), 0);
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    bus.start = 1'b0;
    mode = 0;
    for (int i = 0; i < NP; i++) rnd_tab[i] = W'($urandom_range(N - 1, 0));
    tab[0] = '{1, 143, 37, 76, 1, 1, 1, 0};
    tab[1] = '{0, 180, 0, 76, 0, 0, 0, 0};
    model(2);
    tab[2] = '{2, pre_p[NP-1], pre_f[NP-1], pre_u[NP-1], m_fv, m_fs, m_ft, m_fx};
    model(3);
    tab[3] = '{3, pre_p[NP-1], pre_f[NP-1], pre_u[NP-1], m_fv, m_fs, m_ft, m_fx};
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run(tab[i].md, -1, -1, cyc);
      chk("tab_pass",  int'(bus.pass_cnt),  tab[i].p);
      chk("tab_fail",  int'(bus.fail_cnt),  tab[i].f);
      chk("tab_unsat", int'(bus.unsat_cnt), tab[i].u);
`ifdef SKF_FAIL_LOG_EN
      chk("tab_ff_vld", int'(bus.first_fail_vld), tab[i].fv);
      if (tab[i].fv != 0) begin
        chk("tab_ff_s", int'(bus.first_fail_s), tab[i].fs);
        chk("tab_ff_t", int'(bus.first_fail_t), tab[i].ft);
        chk("tab_ff_x", int'(bus.first_fail_x), tab[i].fx);
      end
`endif
    end
    run(0, 1000, -1, cyc);
    chk("repulse_pass",  int'(bus.pass_cnt),  180);
    chk("repulse_fail",  int'(bus.fail_cnt),  0);
    chk("repulse_unsat", int'(bus.unsat_cnt), 76);
    run(1, -1, 2000, cyc);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, -1, -1, cyc);
    chk("after_reset_pass",  int'(bus.pass_cnt),  180);
    chk("after_reset_fail",  int'(bus.fail_cnt),  0);
    chk("after_reset_unsat", int'(bus.unsat_cnt), 76);
    repeat (20) @(posedge clk);
    #1 chk("idle_hold_pass", int'(bus.pass_cnt), 180);
    chk("idle_hold_unsat", int'(bus.unsat_cnt), 76);
    chk("idle_hold_busy", int'(bus.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
